// File: rtl/snax_gemmx_csr_manager.sv
// -----------------------------------------------------------------------------
// snax_gemmx_csr_manager
//
// Configuration front-end for the GEMMX accelerator shell. Core-side CSR
// requests write a shadow register bank. A write to the START address snapshots
// the shadow bank into a committed bank and presents it to the accelerator
// with a valid/ready handshake. Reads return shadow values, launch status or
// accelerator read-only values through a one-entry response buffer.
//
// Address map (N = RegRWCount, word indices):
//   0 .. N-1            shadow RW registers
//   N                   START (write) / STATUS (read: bit0 = launch pending)
//   N+1 .. N+RegROCount accelerator read-only values
//   N+RegROCount+1      launch counter (only with SNAX_CSR_LAUNCH_COUNTER_EN)
//   anything else       writes ignored, reads return 0
//
// Optional feature macro: SNAX_CSR_LAUNCH_COUNTER_EN
//   Adds a 32-bit wrapping count of completed config handshakes.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   csr_req_*_i / csr_req_ready_o core request channel
//   csr_rsp_*_o / csr_rsp_ready_i read response channel
//   csr_reg_set_o/_valid_o/_ready_i committed config towards accelerator
//   csr_reg_ro_set_i              accelerator read-only values
// -----------------------------------------------------------------------------
module snax_gemmx_csr_manager #(
    parameter int unsigned RegRWCount   = 10,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned RegAddrWidth = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
    input  logic [RegDataWidth-1:0]                  csr_req_data_i,
    input  logic                                     csr_req_write_i,
    input  logic                                     csr_req_valid_i,
    output logic                                     csr_req_ready_o,
    output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
    output logic                                     csr_rsp_valid_o,
    input  logic                                     csr_rsp_ready_i,
    output logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_o,
    output logic                                     csr_reg_set_valid_o,
    input  logic                                     csr_reg_set_ready_i,
    input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i
);

    localparam logic [RegAddrWidth-1:0] StartAddr = RegAddrWidth'(RegRWCount);

    typedef enum logic {
        StIdle,
        StLaunch
    } state_e;

    state_e state_q, state_d;

    logic [RegRWCount-1:0][RegDataWidth-1:0] shadow_q, shadow_d;
    logic [RegRWCount-1:0][RegDataWidth-1:0] commit_q, commit_d;
    logic                                    rsp_valid_q, rsp_valid_d;
    logic [RegDataWidth-1:0]                 rsp_data_q, rsp_data_d;

    logic                    is_start;
    logic                    launch_pending;
    logic                    req_fire;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    cfg_fire;
    logic [RegDataWidth-1:0] rd_data;

`ifdef SNAX_CSR_LAUNCH_COUNTER_EN
    localparam logic [RegAddrWidth-1:0] CntAddr = RegAddrWidth'(RegRWCount + RegROCount + 1);
    logic [31:0] launch_cnt_q, launch_cnt_d;
`endif

    assign is_start       = (csr_req_addr_i == StartAddr);
    assign launch_pending = (state_q == StLaunch);
    assign cfg_fire       = launch_pending & csr_reg_set_ready_i;

    // Start writes stall while a launch is outstanding; reads stall while the
    // single response slot is occupied and not being drained this cycle.
    always_comb begin
        csr_req_ready_o = 1'b1;
        if (csr_req_write_i) begin
            if (is_start && launch_pending) begin
                csr_req_ready_o = 1'b0;
            end
        end else if (rsp_valid_q && !csr_rsp_ready_i) begin
            csr_req_ready_o = 1'b0;
        end
    end

    assign req_fire = csr_req_valid_i & csr_req_ready_o;
    assign wr_fire  = req_fire & csr_req_write_i;
    assign rd_fire  = req_fire & ~csr_req_write_i;

    // Read data mux; unmatched addresses fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < RegRWCount; i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) begin
                rd_data = shadow_q[i];
            end
        end
        if (is_start) begin
            rd_data = {{(RegDataWidth-1){1'b0}}, launch_pending};
        end
        for (int unsigned j = 0; j < RegROCount; j++) begin
            if (csr_req_addr_i == RegAddrWidth'(RegRWCount + 1 + j)) begin
                rd_data = csr_reg_ro_set_i[j];
            end
        end
`ifdef SNAX_CSR_LAUNCH_COUNTER_EN
        if (csr_req_addr_i == CntAddr) begin
            rd_data = RegDataWidth'(launch_cnt_q);
        end
`endif
    end

    // Shadow bank writes are accepted in any state.
    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < RegRWCount; i++) begin
            if (wr_fire && (csr_req_addr_i == RegAddrWidth'(i))) begin
                shadow_d[i] = csr_req_data_i;
            end
        end
    end

    // Launch FSM. The start write is the only write in its cycle, so the
    // committed bank takes the shadow bank as it stands before the edge.
    always_comb begin
        state_d  = state_q;
        commit_d = commit_q;
        case (state_q)
            StIdle: begin
                if (wr_fire && is_start) begin
                    commit_d = shadow_q;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                if (csr_reg_set_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One-entry response buffer; a new read may refill it in the drain cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
        end else if (rsp_valid_q && csr_rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

`ifdef SNAX_CSR_LAUNCH_COUNTER_EN
    always_comb begin
        launch_cnt_d = launch_cnt_q;
        if (cfg_fire) begin
            launch_cnt_d = launch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            launch_cnt_q <= '0;
        end else begin
            launch_cnt_q <= launch_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            commit_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            commit_q    <= commit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign csr_reg_set_o       = commit_q;
    assign csr_reg_set_valid_o = launch_pending;
    assign csr_rsp_valid_o     = rsp_valid_q;
    assign csr_rsp_data_o      = rsp_data_q;

    // Only referenced when the launch counter is built in.
    logic unused_cfg_fire;
    assign unused_cfg_fire = cfg_fire;

endmodule

// File: tb/tb_snax_gemmx_csr_manager.sv
// -----------------------------------------------------------------------------
// Testbench for snax_gemmx_csr_manager: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural register-map model.
// -----------------------------------------------------------------------------
module tb_snax_gemmx_csr_manager;

    localparam int N = 10;

    logic                clk;
    logic                rst;
    logic [31:0]         req_addr;
    logic [31:0]         req_data;
    logic                req_write;
    logic                req_valid;
    logic                req_ready;
    logic [31:0]         rsp_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [N-1:0][31:0]  reg_set;
    logic                reg_set_valid;
    logic                reg_set_ready;
    logic [1:0][31:0]    ro_set;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic [31:0] m_shadow [N];
    logic [31:0] m_commit [N];
    logic        m_launch;
    logic [31:0] m_cnt;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;

`ifdef SNAX_CSR_LAUNCH_COUNTER_EN
    localparam logic [31:0] ExpCnt = 32'd3;
`else
    localparam logic [31:0] ExpCnt = 32'd0;
`endif

    snax_gemmx_csr_manager #(
        .RegRWCount  (N),
        .RegROCount  (2),
        .RegDataWidth(32),
        .RegAddrWidth(32)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .csr_req_addr_i     (req_addr),
        .csr_req_data_i     (req_data),
        .csr_req_write_i    (req_write),
        .csr_req_valid_i    (req_valid),
        .csr_req_ready_o    (req_ready),
        .csr_rsp_data_o     (rsp_data),
        .csr_rsp_valid_o    (rsp_valid),
        .csr_rsp_ready_i    (rsp_ready),
        .csr_reg_set_o      (reg_set),
        .csr_reg_set_valid_o(reg_set_valid),
        .csr_reg_set_ready_i(reg_set_ready),
        .csr_reg_ro_set_i   (ro_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < N) return m_shadow[a[3:0]];
        if (a == N) return {31'b0, m_launch};
        if (a == N + 1) return ro_set[0];
        if (a == N + 2) return ro_set[1];
`ifdef SNAX_CSR_LAUNCH_COUNTER_EN
        if (a == N + 3) return m_cnt;
`endif
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '0;
            m_commit[i] = '0;
        end
        m_launch    = 1'b0;
        m_cnt       = '0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic rr, input logic sr);
        logic        exp_rdy;
        logic [31:0] rv;
        req_valid     = v;
        req_write     = w;
        req_addr      = a;
        req_data      = d;
        rsp_ready     = rr;
        reg_set_ready = sr;
        #1;
        exp_rdy = !(w && a == N && m_launch) && !(!w && m_rsp_valid && !rr);
        check_eq("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        check_eq("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp_valid});
        if (m_rsp_valid) check_eq("rsp_data", rsp_data, m_rsp_data);
        check_eq("set_valid", {31'b0, reg_set_valid}, {31'b0, m_launch});
        if (m_launch) begin
            for (int i = 0; i < N; i++) check_eq("set_reg", reg_set[i], m_commit[i]);
        end
        rv = model_read(a);
        if (m_launch && sr) begin
            m_launch = 1'b0;
            m_cnt    = m_cnt + 32'd1;
        end
        if (v && exp_rdy && !w) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = rv;
        end else if (m_rsp_valid && rr) begin
            m_rsp_valid = 1'b0;
        end
        if (v && exp_rdy && w) begin
            if (a < N) begin
                m_shadow[a[3:0]] = d;
            end else if (a == N) begin
                m_commit = m_shadow;
                m_launch = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic sr);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, sr);
    endtask

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    task automatic async_reset();
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_set_valid", {31'b0, reg_set_valid}, 32'h0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        req_data      = '0;
        rsp_ready     = 1'b1;
        reg_set_ready = 1'b0;
        ro_set        = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check_eq("reset_set_valid", {31'b0, reg_set_valid}, 32'h0);
        check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("reset_rsp_data", rsp_data, 32'h0);
        @(negedge clk);

        // Fill the shadow bank and launch with the accelerator always ready.
        for (int i = 0; i < N; i++) step(1'b1, 1'b1, i, 32'h11 + i, 1'b1, 1'b1);
        step(1'b1, 1'b1, N, 32'h1, 1'b1, 1'b1);
        #1;
        check_eq("launch_valid_hi", {31'b0, reg_set_valid}, 32'h1);
        check_eq("launch_set0", reg_set[0], 32'h11);
        check_eq("launch_set9", reg_set[9], 32'h1A);
        idle(1'b1);
        #1;
        check_eq("launch_valid_lo", {31'b0, reg_set_valid}, 32'h0);

        // Stalled launch: shadow write hidden, second start held off.
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3, 32'hDEAD, 1'b1, 1'b0);
        step(1'b1, 1'b0, N, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
        #1;
        check_eq("set3_hold", reg_set[3], 32'h14);
        check_eq("start_stall", {31'b0, req_ready}, 32'h0);
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
        #1;
        check_eq("relaunch_set3", reg_set[3], 32'hDEAD);
        idle(1'b1);
        step(1'b1, 1'b0, N, 32'h0, 1'b1, 1'b0);
        #1;
        check_eq("status_idle", rsp_data, 32'h0);

        // Read-only registers, back to back.
        ro_set = {32'h55, 32'hAA};
        step(1'b1, 1'b0, N + 1, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, N + 2, 32'h0, 1'b1, 1'b0);
        #1;
        check_eq("ro1_read", rsp_data, 32'h55);
        idle(1'b0);

        // Response held while the consumer stalls.
        step(1'b1, 1'b0, 2, 32'h0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 5, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 200, 32'h0, 1'b1, 1'b0);
        idle(1'b0);

        // Reset with a launch and a response both outstanding.
        step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        async_reset();
        ro_set = '0;
        for (int i = 0; i <= N + 4; i++) step(1'b1, 1'b0, i, 32'h0, 1'b1, 1'b0);
        idle(1'b0);

        // Three completed launches, then read the counter address.
        repeat (3) begin
            step(1'b1, 1'b1, N, 32'h0, 1'b1, 1'b0);
            idle(1'b1);
        end
        step(1'b1, 1'b0, N + 3, 32'h0, 1'b1, 1'b0);
        #1;
        check_eq("launch_count", rsp_data, ExpCnt);
        idle(1'b0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] a;
            int unsigned r;
            ro_set = {$urandom, $urandom};
            r = $urandom_range(0, 15);
            a = (r == 15) ? $urandom : r;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
